// File: rtl/ghash_seq_if.sv
// Block stream handshake between a message source and the GHASH sequencer.
// master drives blocks/subkey and accepts the hash; slave is the sequencer.
//   in_valid/in_ready/in_data/in_is_aad/in_last/subkey_H : block transfer
//   out_valid/out_ready/out_hash                         : final hash
interface ghash_seq_if #(
   parameter int GHASH_BITS  = 128,
   parameter int SUBKEY_BITS = 128
);
   logic                   in_valid;
   logic                   in_ready;
   logic [GHASH_BITS-1:0]  in_data;
   logic                   in_is_aad;
   logic                   in_last;
   logic [SUBKEY_BITS-1:0] subkey_H;
   logic                   out_valid;
   logic                   out_ready;
   logic [GHASH_BITS-1:0]  out_hash;

   modport master (
      output in_valid, in_data, in_is_aad, in_last, subkey_H, out_ready,
      input  in_ready, out_valid, out_hash
   );

   modport slave (
      input  in_valid, in_data, in_is_aad, in_last, subkey_H, out_ready,
      output in_ready, out_valid, out_hash
   );
endinterface

// File: rtl/ghash_seq.sv
// GHASH message sequencer: chains blocks through an external GF(2^128)
// multiply core, appends the length block and presents the final hash.
// Ports: clk, reset (async, active-high); bus (ghash_seq_if.slave) carries
// the block and hash handshakes; ghash_en/ghash_g_prev/ghash_data_block/
// ghash_subkey_H drive the core; ghash_result/ghash_done return from it;
// order_err pulses when an AAD block follows a ciphertext block.
module ghash_seq #(
   parameter int GHASH_BITS  = 128,
   parameter int SUBKEY_BITS = 128,
   parameter int CNT_BITS    = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   ghash_seq_if.slave             bus,
   output logic                   ghash_en,
   output logic [GHASH_BITS-1:0]  ghash_g_prev,
   output logic [GHASH_BITS-1:0]  ghash_data_block,
   output logic [SUBKEY_BITS-1:0] ghash_subkey_H,
   input  logic [GHASH_BITS-1:0]  ghash_result,
   input  logic                   ghash_done,
   output logic                   order_err
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_BLK = 3'd1,
      LEN      = 3'd2,
      WAIT_LEN = 3'd3,
      OUT      = 3'd4
   } state_t;

   state_t state_q, state_d;

   logic [GHASH_BITS-1:0]  acc_q;
   logic [GHASH_BITS-1:0]  blk_q;
   logic [GHASH_BITS-1:0]  hash_q;
   logic [SUBKEY_BITS-1:0] key_q;
   logic [CNT_BITS-1:0]    aad_cnt_q;
   logic [CNT_BITS-1:0]    ct_cnt_q;
   logic                   last_q;
   logic                   first_q;
   logic                   closed_q;
   logic                   busy_q;
   logic                   err_q;

   logic                   accept;
   logic                   blk_done;
   logic                   len_done;
   logic                   release_out;
   logic [63:0]            aad_len;
   logic [63:0]            ct_len;
   logic [GHASH_BITS-1:0]  len_blk;

   assign accept      = (state_q == IDLE) && bus.in_valid;
   // first_q marks the ghash_en cycle, where a done pulse is stale
   assign blk_done    = (state_q == WAIT_BLK) && !first_q && ghash_done;
   assign len_done    = (state_q == WAIT_LEN) && ghash_done;
   assign release_out = (state_q == OUT) && bus.out_ready;

   assign aad_len = 64'(aad_cnt_q) << 7;
   assign ct_len  = 64'(ct_cnt_q) << 7;
   assign len_blk = GHASH_BITS'({aad_len, ct_len});

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     if (bus.in_valid) state_d = WAIT_BLK;
         WAIT_BLK: if (blk_done) state_d = last_q ? LEN : IDLE;
         LEN:      state_d = WAIT_LEN;
         WAIT_LEN: if (ghash_done) state_d = OUT;
         OUT:      if (bus.out_ready) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready     = (state_q == IDLE) && !reset;
      bus.out_valid    = (state_q == OUT);
      ghash_en         = ((state_q == WAIT_BLK) && first_q) ||
                         (state_q == LEN);
      ghash_data_block = blk_q;
      if ((state_q == LEN) || (state_q == WAIT_LEN))
         ghash_data_block = len_blk;
   end

   assign ghash_g_prev   = acc_q;
   assign ghash_subkey_H = key_q;
   assign bus.out_hash   = hash_q;
   assign order_err      = err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q     <= '0;
         blk_q     <= '0;
         hash_q    <= '0;
         key_q     <= '0;
         aad_cnt_q <= '0;
         ct_cnt_q  <= '0;
         last_q    <= 1'b0;
         first_q   <= 1'b0;
         closed_q  <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         first_q <= accept;
         err_q   <= accept && bus.in_is_aad && closed_q;
         if (accept) begin
            blk_q  <= bus.in_data;
            last_q <= bus.in_last;
            busy_q <= 1'b1;
            // subkey is frozen for the whole message
            if (!busy_q) key_q <= bus.subkey_H;
            if (bus.in_is_aad) begin
               aad_cnt_q <= aad_cnt_q + 1'b1;
            end else begin
               ct_cnt_q <= ct_cnt_q + 1'b1;
               closed_q <= 1'b1;
            end
         end
         if (blk_done) acc_q  <= ghash_result;
         if (len_done) hash_q <= ghash_result;
         if (release_out) begin
            acc_q     <= '0;
            aad_cnt_q <= '0;
            ct_cnt_q  <= '0;
            closed_q  <= 1'b0;
            busy_q    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ghash_seq.sv
// Directed bench for ghash_seq with a behavioural GF(2^128) core model.
// The core model answers each ghash_en after a programmable delay.
module tb_ghash_seq;

   logic         clk = 1'b0;
   logic         reset;
   logic         ghash_en;
   logic [127:0] ghash_g_prev;
   logic [127:0] ghash_data_block;
   logic [127:0] ghash_subkey_H;
   logic [127:0] ghash_result;
   logic         ghash_done;
   logic         order_err;

   ghash_seq_if #(.GHASH_BITS(128), .SUBKEY_BITS(128)) bus ();

   ghash_seq #(.GHASH_BITS(128), .SUBKEY_BITS(128), .CNT_BITS(32)) dut (
      .clk              (clk),
      .reset            (reset),
      .bus              (bus),
      .ghash_en         (ghash_en),
      .ghash_g_prev     (ghash_g_prev),
      .ghash_data_block (ghash_data_block),
      .ghash_subkey_H   (ghash_subkey_H),
      .ghash_result     (ghash_result),
      .ghash_done       (ghash_done),
      .order_err        (order_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] gfmul(input logic [127:0] x,
                                          input logic [127:0] y);
      logic [127:0] z, v;
      z = '0;
      v = y;
      for (int i = 127; i >= 0; i--) begin
         if (x[i]) z ^= v;
         if (v[0]) v = (v >> 1) ^ {8'he1, 120'h0};
         else      v = v >> 1;
      end
      return z;
   endfunction

   // core model state
   int           delay = 1;
   int           cnt;
   bit           busy;
   bit           ovr_v;
   logic [127:0] ovr_val;
   logic [127:0] c_gp, c_db, c_key;
   int           en_cnt = 0;
   int           ncall = 0;
   int           err_cnt = 0;
   logic [127:0] gp_log [16];
   logic [127:0] db_log [16];
   logic [127:0] key_log [16];

   always @(negedge clk) begin
      if (reset) begin
         busy       = 1'b0;
         ghash_done = 1'b0;
      end else begin
         ghash_done = 1'b0;
         if (busy) begin
            chk("op_gprev", ghash_g_prev, c_gp);
            chk("op_data", ghash_data_block, c_db);
            chk("op_key", ghash_subkey_H, c_key);
            chk("en_while_busy", 128'(ghash_en), 128'h0);
            cnt--;
            if (cnt <= 0) begin
               ghash_result = ovr_v ? ovr_val : gfmul(c_gp ^ c_db, c_key);
               ovr_v        = 1'b0;
               ghash_done   = 1'b1;
               busy         = 1'b0;
            end
         end else if (ghash_en) begin
            c_gp  = ghash_g_prev;
            c_db  = ghash_data_block;
            c_key = ghash_subkey_H;
            if (ncall < 16) begin
               gp_log[ncall]  = c_gp;
               db_log[ncall]  = c_db;
               key_log[ncall] = c_key;
            end
            ncall++;
            en_cnt++;
            busy = 1'b1;
            cnt  = delay;
         end
      end
   end

   always @(negedge clk) if (order_err) err_cnt++;

   task automatic send(input logic [127:0] d, input bit aad,
                       input bit last, input logic [127:0] h);
      int t;
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_data   = d;
      bus.in_is_aad = aad;
      bus.in_last   = last;
      bus.subkey_H  = h;
      t = 0;
      while (!bus.in_ready && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) chk("send_timeout", 128'(bus.in_ready), 128'h1);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic wait_out(input string tag, input logic [127:0] exp);
      int t;
      t = 0;
      @(negedge clk);
      while (!bus.out_valid && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk({tag, "_valid"}, 128'(bus.out_valid), 128'h1);
      chk({tag, "_hash"}, bus.out_hash, exp);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
   endtask

   localparam logic [127:0] H  = 128'hfe62256362600ac766636f962bb05f66;
   localparam logic [127:0] C1 = 128'h7d924cfd37b3d046a96eb5e132042405;
   localparam logic [127:0] X1 = 128'h0c33e33e3288ca631ca47544293d03ee;

   logic [127:0] blks [5];
   logic [127:0] exp_gp [6];
   logic [127:0] acc, lenb, expv;
   int           en0, low, t;

   initial begin
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_is_aad = 1'b0;
      bus.in_last   = 1'b0;
      bus.subkey_H  = '0;
      bus.out_ready = 1'b0;
      ghash_done    = 1'b0;
      ghash_result  = '0;
      ovr_v         = 1'b0;
      ovr_val       = '0;

      // reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_in_ready", 128'(bus.in_ready), 128'h0);
      chk("rst_out_valid", 128'(bus.out_valid), 128'h0);
      chk("rst_ghash_en", 128'(ghash_en), 128'h0);
      chk("rst_out_hash", bus.out_hash, 128'h0);
      chk("rst_order_err", 128'(order_err), 128'h0);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_release_ready", 128'(bus.in_ready), 128'h1);

      // single ciphertext block, first core answer pinned to X1
      delay   = 1;
      ncall   = 0;
      en0     = en_cnt;
      ovr_v   = 1'b1;
      ovr_val = X1;
      send(C1, 1'b0, 1'b1, H);
      expv = gfmul(X1 ^ 128'h80, H);
      wait_out("t1", expv);
      chk("t1_gp0", gp_log[0], 128'h0);
      chk("t1_db0", db_log[0], C1);
      chk("t1_gp1", gp_log[1], X1);
      chk("t1_db1", db_log[1], 128'h00000000000000000000000000000080);
      chk("t1_en_cnt", 128'(en_cnt - en0), 128'd2);

      // two AAD + three ciphertext; later subkeys must be ignored
      blks[0] = 128'h0123456789abcdef0011223344556677;
      blks[1] = 128'hdeadbeefcafef00d8badf00d12345678;
      blks[2] = 128'h42831ec2217774244b7221b784d0d49c;
      blks[3] = 128'he3aa212f2c02a4e035c17e2329aca12e;
      blks[4] = 128'h21d514b25466931c7d8f6a5aac84aa05;
      acc = '0;
      for (int i = 0; i < 5; i++) begin
         exp_gp[i] = acc;
         acc = gfmul(acc ^ blks[i], H);
      end
      exp_gp[5] = acc;
      lenb = 128'h0000000000000100_0000000000000180;
      expv = gfmul(acc ^ lenb, H);
      ncall = 0;
      for (int i = 0; i < 5; i++)
         send(blks[i], i < 2, i == 4, (i == 0) ? H : ~H);
      wait_out("t2", expv);
      chk("t2_ncall", 128'(ncall), 128'd6);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("t2_gp%0d", i), gp_log[i], exp_gp[i]);
         chk($sformatf("t2_key%0d", i), key_log[i], H);
      end
      chk("t2_len", db_log[5], lenb);

      // slow core, in_valid held high across the wait
      delay = 8;
      ncall = 0;
      en0   = en_cnt;
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_data   = blks[2];
      bus.in_is_aad = 1'b0;
      bus.in_last   = 1'b0;
      bus.subkey_H  = H;
      t = 0;
      while (!bus.in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      @(posedge clk);
      #1;
      bus.in_data = blks[3];
      bus.in_last = 1'b1;
      low = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.in_ready) break;
         low++;
      end
      chk("t3_ready_low", 128'(low), 128'd9);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      acc  = gfmul(gfmul(blks[2], H) ^ blks[3], H);
      expv = gfmul(acc ^ 128'h0000000000000000_0000000000000100, H);
      wait_out("t3", expv);
      chk("t3_en_cnt", 128'(en_cnt - en0), 128'd3);

      // AAD after ciphertext
      delay = 1;
      ncall = 0;
      err_cnt = 0;
      send(blks[0], 1'b0, 1'b0, H);
      send(blks[1], 1'b1, 1'b0, H);
      send(blks[4], 1'b0, 1'b1, H);
      acc = gfmul(blks[0], H);
      acc = gfmul(acc ^ blks[1], H);
      acc = gfmul(acc ^ blks[4], H);
      lenb = 128'h0000000000000080_0000000000000100;
      expv = gfmul(acc ^ lenb, H);
      wait_out("t4", expv);
      chk("t4_err_pulses", 128'(err_cnt), 128'd1);
      chk("t4_len", db_log[3], lenb);

      // reset during WAIT_LEN
      delay = 8;
      ncall = 0;
      send(blks[3], 1'b1, 1'b1, H);
      t = 0;
      while (ncall < 2 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("t5_reach_len", 128'(ncall), 128'd2);
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("t5_in_ready", 128'(bus.in_ready), 128'h0);
      chk("t5_out_valid", 128'(bus.out_valid), 128'h0);
      chk("t5_en", 128'(ghash_en), 128'h0);
      chk("t5_gprev", ghash_g_prev, 128'h0);
      chk("t5_data", ghash_data_block, 128'h0);
      chk("t5_key", ghash_subkey_H, 128'h0);
      chk("t5_hash", bus.out_hash, 128'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("t5_ready_after", 128'(bus.in_ready), 128'h1);
      delay = 2;
      ncall = 0;
      send(blks[4], 1'b0, 1'b1, H);
      lenb = 128'h0000000000000000_0000000000000080;
      expv = gfmul(gfmul(blks[4], H) ^ lenb, H);
      wait_out("t5", expv);
      chk("t5_gp0", gp_log[0], 128'h0);
      chk("t5_len", db_log[1], lenb);

      // output back-pressure
      delay = 1;
      ncall = 0;
      send(blks[1], 1'b1, 1'b1, H);
      lenb = 128'h0000000000000080_0000000000000000;
      expv = gfmul(gfmul(blks[1], H) ^ lenb, H);
      t = 0;
      @(negedge clk);
      while (!bus.out_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      en0 = en_cnt;
      for (int i = 0; i < 5; i++) begin
         chk("t6_valid", 128'(bus.out_valid), 128'h1);
         chk("t6_hash", bus.out_hash, expv);
         chk("t6_ready", 128'(bus.in_ready), 128'h0);
         @(negedge clk);
      end
      chk("t6_no_core", 128'(en_cnt - en0), 128'd0);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      chk("t6_idle_ready", 128'(bus.in_ready), 128'h1);
      chk("t6_valid_off", 128'(bus.out_valid), 128'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/ghash_seq.md
GHASH_SEQ -- requirements
Module: ghash_seq

Interface
REQ-001 Parameter: GHASH_BITS, 128, width of data blocks, hash accumulator and length block.
REQ-002 Parameter: SUBKEY_BITS, 128, width of hash subkey H.
REQ-003 Parameter: CNT_BITS, 32, width of each block counter (AAD and ciphertext).
REQ-004 Ports: clk in 1, sole clock; all state updates on rising edge.
REQ-005 Ports: reset in 1, asynchronous, active-high.
REQ-006 Ports: in_valid in 1 / in_ready out 1, upstream block handshake; transfer when both high at a rising edge.
REQ-007 Ports: in_data in GHASH_BITS, one full block; in_is_aad in 1, block is AAD; in_last in 1, final block of message.
REQ-008 Ports: subkey_H in SUBKEY_BITS, hash subkey for the message.
REQ-009 Ports: ghash_en out 1, start pulse to the GHASH core.
REQ-010 Ports: ghash_g_prev out GHASH_BITS, ghash_data_block out GHASH_BITS, ghash_subkey_H out SUBKEY_BITS, core operands.
REQ-011 Ports: ghash_result in GHASH_BITS, ghash_done in 1, core result and one-cycle completion pulse.
REQ-012 Ports: out_valid out 1 / out_ready in 1 / out_hash out GHASH_BITS, final GHASH value of the message.
REQ-013 Ports: order_err out 1, one-cycle flag for an AAD block accepted after a ciphertext block.

Function
REQ-014 States SHALL be IDLE, WAIT_BLK, LEN, WAIT_LEN, OUT; reset state IDLE.
REQ-015 in_ready SHALL be high only in IDLE.
REQ-016 On acceptance in IDLE: latch in_data, in_last and subkey_H, increment the AAD or ciphertext counter per in_is_aad, go to WAIT_BLK.
REQ-017 ghash_en SHALL be high for exactly the one cycle following acceptance (the first WAIT_BLK cycle), with ghash_g_prev = accumulator, ghash_data_block = latched block and ghash_subkey_H = latched subkey.
REQ-018 Operand outputs SHALL hold stable from the ghash_en cycle until ghash_done is sampled.
REQ-019 In WAIT_BLK, ghash_done sampled high SHALL load accumulator <= ghash_result; next state LEN if latched in_last, else IDLE.
REQ-020 In LEN, ghash_en SHALL pulse one cycle with ghash_data_block = {64-bit AAD bit length, 64-bit ciphertext bit length}, g_prev = accumulator, same subkey; next state WAIT_LEN.
REQ-021 Each bit length SHALL equal its block count shifted left by 7, zero-extended to 64 bits.
REQ-022 In WAIT_LEN, ghash_done SHALL load out_hash <= ghash_result and move to OUT.
REQ-023 In OUT, out_valid SHALL be high; on out_ready, clear accumulator, both counters and the AAD-closed flag, and go to IDLE.
REQ-024 ghash_done outside WAIT_BLK/WAIT_LEN, or during the ghash_en cycle itself, SHALL be ignored.
REQ-025 Counters SHALL wrap modulo 2^CNT_BITS without flagging.
REQ-026 Accepting a block with in_is_aad=1 after any in_is_aad=0 block of the same message SHALL pulse order_err for one cycle; the block is still hashed and counted as AAD.
REQ-027 A message of AAD-only or ciphertext-only blocks SHALL be legal; a zero count yields a zero 64-bit field.
REQ-028 subkey_H changes while a message is in progress SHALL be ignored until the next message's first block.

Reset
REQ-029 Reset asserted at any time, including mid-WAIT or OUT, SHALL immediately force state IDLE, all outputs low/zero, and accumulator, counters, latches and AAD-closed flag to zero.
REQ-030 in_ready SHALL rise the first cycle after reset deassertion.

Verification
REQ-031 Single-block test: H=fe62256362600ac766636f962bb05f66, one ciphertext block 7d924cfd37b3d046a96eb5e132042405 with in_last -> first core call g_prev=0, core returns 0c33e33e3288ca631ca47544293d03ee; second call g_prev=0c33e33e3288ca631ca47544293d03ee, data=00000000000000000000000000000080; out_hash equals the model result.
REQ-032 Two AAD blocks plus three ciphertext blocks -> five chained core calls, then length block 0000000000000100_0000000000000180; out_hash matches the reference model.
REQ-033 Core done delayed 8 cycles with in_valid held high -> in_ready low throughout, operands stable, exactly one ghash_en per block.
REQ-034 AAD after ciphertext -> order_err pulses exactly once, the block is counted as AAD, hashing continues.
REQ-035 Reset pulsed during WAIT_LEN -> all outputs zero asynchronously; the next message hashes from a zero accumulator with correct lengths.
REQ-036 out_ready held low for 5 cycles -> out_valid and out_hash stable, in_ready low, no core activity; on out_ready, IDLE in the next cycle.
